// File: rtl/clock_seq_pkg.sv
// Shared state encoding and default constants for the Hack clock sequencer.
// Imported by clock_sequencer and clock_phase_counter.
package clock_seq_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_STEP = 2'd3
    } state_e;

    localparam int DEF_DIV        = 3;
    localparam int DEF_RST_CYCLES = 16;

endpackage

// File: rtl/clock_phase_counter.sv
// Free-running divide-by-DIV phase counter (0..DIV-1, wraps to 0).
// Ports: clk, reset (sync, active-high), phase (count), wrap (phase == DIV-1).
module clock_phase_counter
    import clock_seq_pkg::*;
#(
    parameter int DIV = DEF_DIV,
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          reset,
    output logic [PW-1:0] phase,
    output logic          wrap
);

    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    always_comb begin
        phase_d = phase_q + PW'(1);
        if (phase_q == LAST) begin
            phase_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;
    assign wrap  = (phase_q == LAST);

endmodule

// File: rtl/clock_sequencer.sv
// Hack CPU clock sequencer: divided clock-enable, reset stretch, run/halt/step.
// Ports: clk, reset, run, step in; cpu_ce, cpu_reset, clk_out, halted, step_ack out.
module clock_sequencer
    import clock_seq_pkg::*;
#(
    parameter int DIV        = DEF_DIV,
    parameter int RST_CYCLES = DEF_RST_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic step,
    output logic cpu_ce,
    output logic cpu_reset,
    output logic clk_out,
    output logic halted,
    output logic step_ack
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = (RST_CYCLES > 0) ? $clog2(RST_CYCLES + 1) : 1;

    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0] RC_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] RC_DONE = CW'(RST_CYCLES);

    logic [PW-1:0] phase;
    logic          wrap;
    logic          tick;

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] rst_cnt_q;
    logic [CW-1:0] rst_cnt_d;

    clock_phase_counter #(
        .DIV(DIV)
    ) u_phase (
        .clk  (clk),
        .reset(reset),
        .phase(phase),
        .wrap (wrap)
    );

    // Every Hack tick lands on the last phase, so ticks stay DIV-aligned
    // across any state change.
    assign tick = (phase == PH_LAST);

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        unique case (state_q)
            ST_INIT: begin
                if (tick) begin
                    if (rst_cnt_q == RC_LAST) begin
                        rst_cnt_d = RC_DONE;
                        state_d   = run ? ST_RUN : ST_HALT;
                    end else begin
                        rst_cnt_d = rst_cnt_q + CW'(1);
                    end
                end
            end
            ST_RUN: begin
                if (!run) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (run) begin
                    state_d = ST_RUN;
                end else if (step) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (tick) begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_INIT;
            rst_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
        end
    end

    // Outputs decode only registered state and phase.
    assign cpu_ce    = tick && (state_q != ST_HALT);
    assign cpu_reset = (state_q == ST_INIT);
    assign clk_out   = wrap;
    assign halted    = (state_q == ST_HALT);
    assign step_ack  = tick && (state_q == ST_STEP);

endmodule
